heap_feeder: RTL and testbench

HEAP_FEEDER -- requirements
Module: heap_feeder

---
 rtl/heap_feeder.sv | 180 ++++++++++++++++++
 tb/tb_heap_feeder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/heap_feeder.sv
// heap_feeder: frames a stream of items into a hardware heap and drains it.
// A frame runs IDLE -> INIT -> FILL -> DRAIN -> FLUSH -> IDLE. The heap
// absorbs one item per two cycles, so FILL inserts a gap cycle after every
// accept. Optional build macro HEAP_FEEDER_ZKEY_DROP_EN: accepted items whose
// key field is all-zero are handshaken but not written into the heap.
module heap_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int KEY_WIDTH  = 4,
  parameter int NLEVELS    = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  frame_start,
  input  logic                  frame_end,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-3:0] in_data,
  output logic [DATA_WIDTH-1:0] heap_din,
  output logic                  heap_en,
  output logic                  heap_init,
  output logic                  heap_flush,
  input  logic [DATA_WIDTH-1:0] heap_dout,
  input  logic                  heap_valid,
  input  logic                  heap_empty,
  output logic                  out_valid,
  output logic [DATA_WIDTH-3:0] out_data,
  output logic                  done,
  output logic                  busy
);

  localparam int HEAP_SIZE = (2 ** (NLEVELS + 1)) - 1;

  // Elaboration-time sanity checks on the configuration.
  if (KEY_WIDTH < 1 || KEY_WIDTH > DATA_WIDTH - 2) begin : g_bad_key
    $error("heap_feeder: KEY_WIDTH must fit inside the item payload");
  end
  if (HEAP_SIZE < 1) begin : g_bad_levels
    $error("heap_feeder: NLEVELS yields an empty heap");
  end

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    FILL,
    DRAIN,
    FLUSH
  } state_t;

  state_t                state_q;
  logic [1:0]            gap_q;
  logic                  drain_q;
  logic                  in_ready_q;
  logic                  heap_init_q;
  logic                  heap_flush_q;
  logic                  out_valid_q;
  logic                  done_q;
  logic                  busy_q;
  logic [DATA_WIDTH-1:0] heap_din_q;
  logic [DATA_WIDTH-1:0] heap_din_d;
  logic [DATA_WIDTH-3:0] out_data_q;
  logic                  accept;
  logic                  issue;

  // The two heap-word flag bits are never forwarded downstream.
  logic unused_dout_msbs;
  assign unused_dout_msbs = ^heap_dout[DATA_WIDTH-1:DATA_WIDTH-2];

  // Handshake and heap write strobe, combinational from the registered ready.
  always_comb begin
    accept = in_valid & in_ready_q;
`ifdef HEAP_FEEDER_ZKEY_DROP_EN
    issue  = accept & (|in_data[KEY_WIDTH-1:0]);
`else
    issue  = accept;
`endif
    heap_din_d = heap_din_q;
    if (issue) begin
      heap_din_d = {2'b00, in_data};
    end
  end

  assign in_ready   = in_ready_q;
  assign heap_en    = issue;
  assign heap_din   = heap_din_d;
  assign heap_init  = heap_init_q;
  assign heap_flush = heap_flush_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign done       = done_q;
  assign busy       = busy_q;

  // Frame sequencing FSM; every output it drives is registered.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      gap_q        <= '0;
      drain_q      <= 1'b0;
      in_ready_q   <= 1'b0;
      heap_init_q  <= 1'b0;
      heap_flush_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      heap_din_q   <= '0;
    end else begin
      heap_din_q  <= heap_din_d;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b0;
          if (frame_start) begin
            state_q     <= INIT;
            heap_init_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        INIT: begin
          heap_init_q <= 1'b0;
          gap_q       <= '0;
          in_ready_q  <= 1'b1;
          state_q     <= FILL;
        end
        FILL: begin
          // frame_end wins over the gap logic; a same-cycle accept has
          // already been issued combinationally.
          if (frame_end) begin
            state_q    <= DRAIN;
            in_ready_q <= 1'b0;
            gap_q      <= '0;
            drain_q    <= 1'b0;
          end else if (accept) begin
            gap_q      <= 2'd1;
            in_ready_q <= 1'b0;
          end else if (gap_q != 2'd0) begin
            gap_q      <= gap_q - 2'd1;
            in_ready_q <= (gap_q == 2'd1);
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        DRAIN: begin
          in_ready_q <= 1'b0;
          if (drain_q) begin
            state_q      <= FLUSH;
            heap_flush_q <= 1'b1;
            out_valid_q  <= heap_valid;
            if (heap_valid) begin
              out_data_q <= heap_dout[DATA_WIDTH-3:0];
            end
          end else begin
            drain_q <= 1'b1;
          end
        end
        FLUSH: begin
          if (heap_empty) begin
            state_q      <= IDLE;
            heap_flush_q <= 1'b0;
            done_q       <= 1'b1;
            busy_q       <= 1'b0;
          end else begin
            out_valid_q <= heap_valid;
            if (heap_valid) begin
              out_data_q <= heap_dout[DATA_WIDTH-3:0];
            end
          end
        end
        default: begin
          state_q      <= IDLE;
          in_ready_q   <= 1'b0;
          heap_init_q  <= 1'b0;
          heap_flush_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_heap_feeder.sv
// Directed bench for heap_feeder (DATA_WIDTH=8, KEY_WIDTH=4, NLEVELS=2).
// The heap side is driven by hand: heap_valid/heap_dout/heap_empty.
module tb_heap_feeder;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       frame_start = 1'b0;
  logic       frame_end = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [5:0] in_data = '0;
  logic [7:0] heap_din;
  logic       heap_en;
  logic       heap_init;
  logic       heap_flush;
  logic [7:0] heap_dout = '0;
  logic       heap_valid = 1'b0;
  logic       heap_empty = 1'b0;
  logic       out_valid;
  logic [5:0] out_data;
  logic       done;
  logic       busy;

  int n_pass  = 0;
  int n_total = 0;
  int en_cnt  = 0;

`ifdef HEAP_FEEDER_ZKEY_DROP_EN
  localparam bit ZKEY_EN = 1'b0;
  localparam int ZKEY_CNT = 2;
`else
  localparam bit ZKEY_EN = 1'b1;
  localparam int ZKEY_CNT = 4;
`endif

  heap_feeder #(.DATA_WIDTH(8), .KEY_WIDTH(4), .NLEVELS(2)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .frame_start(frame_start),
    .frame_end  (frame_end),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .heap_din   (heap_din),
    .heap_en    (heap_en),
    .heap_init  (heap_init),
    .heap_flush (heap_flush),
    .heap_dout  (heap_dout),
    .heap_valid (heap_valid),
    .heap_empty (heap_empty),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .done       (done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one item with in_valid held; wait for ready (bounded), checking
  // that no write leaks out in gap cycles, then complete the handshake.
  task automatic feed(input logic [5:0] d, input bit fend, input int exp_wait, input bit exp_en);
    int w = 0;
    in_valid = 1'b1;
    in_data  = d;
    #1;
    while (!in_ready && w < 4) begin
      check("gap_no_en", heap_en, 0);
      step();
      w++;
    end
    check("gap_cycles", w, exp_wait);
    frame_end = fend;
    #1;
    check("accept_en", heap_en, exp_en);
    if (exp_en) check("accept_din", heap_din, {2'b00, d});
    en_cnt += int'(heap_en);
    step();
    frame_end = 1'b0;
  endtask

  initial begin
    // Asynchronous reset before any clock edge.
    #2 rstn = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_ready", in_ready, 0);
    check("rst_din", heap_din, 0);
    check("rst_flags", {heap_en, heap_init, heap_flush, out_valid, done}, 0);
    check("rst_out_data", out_data, 0);
    step(); step();
    rstn = 1'b1;
    step();

    // frame_end in IDLE is ignored.
    frame_end = 1'b1;
    step();
    frame_end = 1'b0;
    check("idle_busy", busy, 0);
    check("idle_ready", in_ready, 0);

    // Frame A: four items with in_valid held, a fifth with frame_end.
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check("init_pulse", heap_init, 1);
    check("init_busy", busy, 1);
    check("init_ready", in_ready, 0);
    step();
    check("fill_init_low", heap_init, 0);
    check("fill_ready", in_ready, 1);
    feed(6'h11, 1'b0, 0, 1'b1);
    feed(6'h22, 1'b0, 1, 1'b1);
    feed(6'h33, 1'b0, 1, 1'b1);
    feed(6'h2C, 1'b0, 1, 1'b1);
    feed(6'h35, 1'b1, 1, 1'b1);
    // Now in DRAIN cycle 1; in_valid still high must not be consumed.
    check("en_count_a", en_cnt, 5);
    check("drain1_ready", in_ready, 0);
    check("drain1_en", heap_en, 0);
    check("drain1_flush", heap_flush, 0);
    check("drain_din_hold", heap_din, 8'h35);
    in_valid   = 1'b0;
    heap_valid = 1'b1;
    heap_dout  = 8'hFF;
    step();
    check("drain2_ready", in_ready, 0);
    check("drain2_flush", heap_flush, 0);
    check("drain2_no_out", out_valid, 0);
    heap_valid = 1'b0;
    step();
    check("flush_rise", heap_flush, 1);
    check("flush1_no_out", out_valid, 0);
    heap_valid = 1'b1;
    heap_dout  = 8'hC5;
    step();
    check("flush_out_v1", out_valid, 1);
    check("flush_out_d1", out_data, 6'h05);
    check("flush_held", heap_flush, 1);
    heap_dout  = 8'h4A;
    step();
    check("flush_out_v2", out_valid, 1);
    check("flush_out_d2", out_data, 6'h0A);
    heap_valid = 1'b0;
    heap_empty = 1'b1;
    step();
    check("end_flush_low", heap_flush, 0);
    check("end_done", done, 1);
    check("end_busy", busy, 0);
    check("end_out_v", out_valid, 0);
    heap_empty = 1'b0;
    step();
    check("done_one_cycle", done, 0);

    // Empty frame; a stray frame_start in FILL must not re-init.
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    step();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check("fill_restart_ignored", heap_init, 0);
    check("fill_restart_busy", busy, 1);
    frame_end = 1'b1;
    step();
    frame_end = 1'b0;
    check("empty_drain_ready", in_ready, 0);
    check("empty_drain_flush", heap_flush, 0);
    step();
    step();
    check("empty_flush", heap_flush, 1);
    heap_empty = 1'b1;
    step();
    check("empty_done", done, 1);
    check("empty_busy", busy, 0);
    heap_empty = 1'b0;
    step();

    // Reset mid-FILL after three accepts.
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    step();
    feed(6'h01, 1'b0, 0, 1'b1);
    feed(6'h02, 1'b0, 1, 1'b1);
    feed(6'h03, 1'b0, 1, 1'b1);
    step();
    check("pre_rst_ready", in_ready, 1);
    rstn = 1'b0;
    #1;
    check("mid_rst_ready", in_ready, 0);
    check("mid_rst_en", heap_en, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_din", heap_din, 0);
    check("mid_rst_flags", {heap_init, heap_flush, out_valid, done}, 0);
    in_valid = 1'b0;
    step();
    rstn = 1'b1;
    step();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check("reinit_pulse", heap_init, 1);
    step();
    check("reinit_ready", in_ready, 1);

    // Zero-key items: dropped from the heap only when the option is built in.
    en_cnt = 0;
    feed(6'h10, 1'b0, 0, ZKEY_EN);
    feed(6'h25, 1'b0, 1, 1'b1);
    feed(6'h30, 1'b0, 1, ZKEY_EN);
    feed(6'h33, 1'b1, 1, 1'b1);
    in_valid = 1'b0;
    check("zkey_en_count", en_cnt, ZKEY_CNT);
    check("zkey_din_last", heap_din, 8'h33);
    step();
    step();
    heap_empty = 1'b1;
    step();
    check("zkey_done", done, 1);
    heap_empty = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
